// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 exception unit: register numbers, field
// positions inside SR and Cause, and the exception codes the pipeline reports.
package cp0_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exccode_e;

    // EXL alone selects the mode; the enum only names the two cases.
    typedef enum logic {
        MODE_NORMAL  = 1'b0,
        MODE_HANDLER = 1'b1
    } mode_e;

    function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                            input logic       exl,
                                            input logic       ie);
        logic [31:0] word;
        word = '0;
        word[SR_IM_HI:SR_IM_LO] = im;
        word[SR_EXL]            = exl;
        word[SR_IE]             = ie;
        return word;
    endfunction

    function automatic logic [31:0] pack_cause(input logic       bd,
                                               input logic [5:0] ip,
                                               input logic [4:0] code);
        logic [31:0] word;
        word = '0;
        word[CAUSE_BD]                  = bd;
        word[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
        word[CAUSE_EXC_HI:CAUSE_EXC_LO] = code;
        return word;
    endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// Pipeline-to-CP0 bundle: M-stage exception info, interrupt lines, MTC0/MFC0
// access and the redirect request sent back to fetch.
interface cp0_exc_unit_if;

    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exccode_m;
    logic [5:0]  hwint;
    logic        eret_m;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exc_req;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output pc_m, bd_m, exccode_m, hwint, eret_m, we, addr, wdata,
        input  rdata, exc_req, redirect, redirect_pc
    );

    modport slave (
        input  pc_m, bd_m, exccode_m, hwint, eret_m, we, addr, wdata,
        output rdata, exc_req, redirect, redirect_pc
    );

endinterface

// File: rtl/cp0_exc_unit.sv
// CP0 exception unit: holds SR/Cause/EPC/PRId, decides in the same cycle
// whether to take an interrupt or exception, and handles ERET and MTC0/MFC0.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] PRID_VALUE = 32'h1234_5678
) (
    input logic             clk,
    input logic             reset_n,
    cp0_exc_unit_if.slave   bus
);

    logic [5:0]  sr_im,     sr_im_nxt;
    logic        sr_exl,    sr_exl_nxt;
    logic        sr_ie,     sr_ie_nxt;
    logic        cause_bd,  cause_bd_nxt;
    logic [5:0]  cause_ip,  cause_ip_nxt;
    logic [4:0]  cause_exc, cause_exc_nxt;
    logic [31:0] epc,       epc_nxt;

    mode_e       mode;
    logic        int_pend;
    logic        sync_exc;
    logic        exc_req;
    logic        eret_ok;
    logic [31:0] epc_target;

    // Interrupts use the live hwint lines so they are taken with no lag.
    always_comb begin
        mode     = sr_exl ? MODE_HANDLER : MODE_NORMAL;
        int_pend = (|(bus.hwint & sr_im)) && sr_ie && (mode == MODE_NORMAL);
        sync_exc = (bus.exccode_m != 5'd0) && (mode == MODE_NORMAL);
        exc_req  = reset_n && (int_pend || sync_exc);
        eret_ok  = reset_n && bus.eret_m && (mode == MODE_HANDLER) && !exc_req;
    end

    // A delay-slot instruction restarts from its branch, one word earlier.
    always_comb begin
        epc_target = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
        epc_target = epc_target & 32'hFFFF_FFFC;
    end

    always_comb begin
        bus.exc_req     = exc_req;
        bus.redirect    = exc_req || eret_ok;
        bus.redirect_pc = exc_req ? EXC_VECTOR : epc;
    end

    // Exception entry beats ERET, which beats an MTC0 issued in the same cycle.
    always_comb begin
        sr_im_nxt     = sr_im;
        sr_exl_nxt    = sr_exl;
        sr_ie_nxt     = sr_ie;
        cause_bd_nxt  = cause_bd;
        cause_ip_nxt  = bus.hwint;
        cause_exc_nxt = cause_exc;
        epc_nxt       = epc;

        if (exc_req) begin
            sr_exl_nxt    = 1'b1;
            cause_exc_nxt = int_pend ? EXC_INT : bus.exccode_m;
            cause_bd_nxt  = bus.bd_m;
            epc_nxt       = epc_target;
        end else if (eret_ok) begin
            sr_exl_nxt = 1'b0;
        end else if (bus.we) begin
            case (bus.addr)
                REG_SR: begin
                    sr_im_nxt  = bus.wdata[SR_IM_HI:SR_IM_LO];
                    sr_exl_nxt = bus.wdata[SR_EXL];
                    sr_ie_nxt  = bus.wdata[SR_IE];
                end
                REG_EPC: epc_nxt = bus.wdata & 32'hFFFF_FFFC;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            sr_im     <= sr_im_nxt;
            sr_exl    <= sr_exl_nxt;
            sr_ie     <= sr_ie_nxt;
            cause_bd  <= cause_bd_nxt;
            cause_ip  <= cause_ip_nxt;
            cause_exc <= cause_exc_nxt;
            epc       <= epc_nxt;
        end
    end

    // Reads return the stored contents; a write in this cycle is not bypassed.
    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            REG_SR:    bus.rdata = pack_sr(sr_im, sr_exl, sr_ie);
            REG_CAUSE: bus.rdata = pack_cause(cause_bd, cause_ip, cause_exc);
            REG_EPC:   bus.rdata = epc;
            REG_PRID:  bus.rdata = PRID_VALUE;
            default:   bus.rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed scenarios followed by random
// traffic, all compared against a word-level model of the CP0 registers.
module tb_cp0_exc_unit;

    localparam logic [31:0] VEC  = 32'h0000_4180;
    localparam logic [31:0] PRID = 32'h1234_5678;

    logic clk = 1'b0;
    logic reset_n;
    cp0_exc_unit_if bus();

    cp0_exc_unit #(.EXC_VECTOR(VEC), .PRID_VALUE(PRID)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state kept as plain register words
    logic [31:0] mSr;
    logic [31:0] mCause;
    logic [31:0] mEpc;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        mSr    = 32'd0;
        mCause = 32'd0;
        mEpc   = 32'd0;
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        case (a)
            5'd12:   return mSr;
            5'd13:   return mCause;
            5'd14:   return mEpc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic modelIntPend();
        logic [31:0] im;
        im = (mSr >> 10) & 32'h3F;
        return ((im & 32'(bus.hwint)) != 0) && (mSr[0] == 1'b1) && (mSr[1] == 1'b0);
    endfunction

    function automatic logic modelExcReq();
        if (!reset_n) return 1'b0;
        return modelIntPend() || ((bus.exccode_m != 0) && (mSr[1] == 1'b0));
    endfunction

    function automatic logic modelEretOk();
        return reset_n && bus.eret_m && (mSr[1] == 1'b1) && !modelExcReq();
    endfunction

    task automatic modelUpdate();
        logic        exc;
        logic        eret;
        logic        intp;
        logic [31:0] code;
        logic [31:0] bdv;
        logic [31:0] pcv;
        exc  = modelExcReq();
        eret = modelEretOk();
        intp = modelIntPend();
        code = (mCause >> 2) & 32'h1F;
        bdv  = mCause >> 31;
        if (exc) begin
            mSr  = mSr | 32'h2;
            code = intp ? 32'd0 : 32'(bus.exccode_m);
            bdv  = 32'(bus.bd_m);
            pcv  = bus.bd_m ? bus.pc_m - 32'd4 : bus.pc_m;
            mEpc = pcv - (pcv % 4);
        end else if (eret) begin
            mSr = mSr & ~32'h2;
        end else if (bus.we) begin
            if (bus.addr == 5'd12) mSr  = bus.wdata & 32'h0000_FC03;
            if (bus.addr == 5'd14) mEpc = bus.wdata - (bus.wdata % 4);
        end
        mCause = (bdv << 31) + (32'(bus.hwint) << 10) + (code << 2);
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                                 input logic [5:0] hwint, input logic [31:0] pc, input logic bd,
                                 input logic [4:0] code, input logic eret);
        bus.we        = we;
        bus.addr      = addr;
        bus.wdata     = wdata;
        bus.hwint     = hwint;
        bus.pc_m      = pc;
        bus.bd_m      = bd;
        bus.exccode_m = code;
        bus.eret_m    = eret;
    endtask

    task automatic checkNow(input string tag);
        logic exc;
        logic red;
        exc = modelExcReq();
        red = exc || modelEretOk();
        checkOutput({tag, ".exc_req"},     32'(bus.exc_req),  32'(exc));
        checkOutput({tag, ".redirect"},    32'(bus.redirect), 32'(red));
        checkOutput({tag, ".redirect_pc"}, bus.redirect_pc,   exc ? VEC : mEpc);
        checkOutput({tag, ".rdata"},       bus.rdata,         modelRead(bus.addr));
    endtask

    task automatic stepCycle(input string tag);
        @(negedge clk);
        checkNow(tag);
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic readReg(input logic [4:0] a, input logic [31:0] want, input string tag);
        applyStimulus(1'b0, a, 32'd0, 6'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput(tag, bus.rdata, want);
        stepCycle({tag, ".cyc"});
    endtask

    initial begin
        logic [4:0] addrs [5];
        logic [4:0] codes [6];
        addrs = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        codes = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd12, 5'd0};

        reset_n = 1'b0;
        modelReset();
        applyStimulus(1'b0, 5'd12, 32'd0, 6'd0, 32'd0, 1'b0, 5'd7, 1'b0);
        #12;
        checkOutput("rst.exc_req", 32'(bus.exc_req), 32'd0);
        checkOutput("rst.redirect_pc", bus.redirect_pc, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        readReg(5'd12, 32'd0, "init.sr");
        readReg(5'd13, 32'd0, "init.cause");
        readReg(5'd14, 32'd0, "init.epc");
        readReg(5'd15, 32'h1234_5678, "init.prid");

        // Interrupt entry
        applyStimulus(1'b1, 5'd12, 32'h0000_0401, 6'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        stepCycle("mtc0.sr");
        applyStimulus(1'b0, 5'd14, 32'd0, 6'b000001, 32'h0000_3010, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("int.exc_req", 32'(bus.exc_req), 32'd1);
        checkOutput("int.vector", bus.redirect_pc, 32'h0000_4180);
        stepCycle("int");
        readReg(5'd14, 32'h0000_3010, "int.epc");
        readReg(5'd12, 32'h0000_0403, "int.sr_exl");

        // Leave handler, then synchronous exception in a delay slot
        applyStimulus(1'b0, 5'd12, 32'd0, 6'd0, 32'd0, 1'b0, 5'd0, 1'b1);
        #1;
        checkOutput("eret.redirect", 32'(bus.redirect), 32'd1);
        checkOutput("eret.pc", bus.redirect_pc, 32'h0000_3010);
        stepCycle("eret");
        applyStimulus(1'b0, 5'd13, 32'd0, 6'd0, 32'h0000_3024, 1'b1, 5'd12, 1'b0);
        stepCycle("ov");
        readReg(5'd14, 32'h0000_3020, "ov.epc");
        readReg(5'd13, 32'h8000_0030, "ov.cause");
        applyStimulus(1'b0, 5'd12, 32'd0, 6'd0, 32'h0000_3100, 1'b0, 5'd10, 1'b0);
        #1;
        checkOutput("nested.exc_req", 32'(bus.exc_req), 32'd0);
        stepCycle("nested");
        applyStimulus(1'b0, 5'd12, 32'd0, 6'd0, 32'd0, 1'b0, 5'd0, 1'b1);
        stepCycle("eret2");
        applyStimulus(1'b0, 5'd12, 32'd0, 6'd0, 32'd0, 1'b0, 5'd0, 1'b1);
        #1;
        checkOutput("eret_normal.redirect", 32'(bus.redirect), 32'd0);
        stepCycle("eret_normal");

        // Interrupt wins over exception and over a same-cycle MTC0
        applyStimulus(1'b1, 5'd14, 32'hDEAD_BEEF, 6'b000001, 32'h0000_5008, 1'b0, 5'd4, 1'b0);
        stepCycle("prio");
        readReg(5'd14, 32'h0000_5008, "prio.epc");
        readReg(5'd13, 32'h0000_0000, "prio.cause");

        // Reset asserted between edges while in the handler
        #2;
        reset_n = 1'b0;
        modelReset();
        applyStimulus(1'b0, 5'd12, 32'd0, 6'b000001, 32'h0000_6000, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("midrst.sr", bus.rdata, 32'd0);
        bus.addr = 5'd14;
        #1;
        checkOutput("midrst.epc", bus.rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, 5'd12, 32'd0, 6'b111111, 32'h0000_6000, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("midrst.blocked", 32'(bus.exc_req), 32'd0);
        stepCycle("midrst");

        // Address wrap on a delay-slot instruction at PC 0
        applyStimulus(1'b0, 5'd14, 32'd0, 6'd0, 32'h0000_0000, 1'b1, 5'd5, 1'b0);
        stepCycle("wrap");
        readReg(5'd14, 32'hFFFF_FFFC, "wrap.epc");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 2) == 0),
                          addrs[$urandom_range(0, 4)],
                          $urandom(),
                          ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'd0,
                          $urandom(),
                          1'($urandom()),
                          ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 5)] : 5'd0,
                          ($urandom_range(0, 3) == 0));
            stepCycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
